pattern_writer: RTL and testbench

Wishbone master that fills the SDRAM frame buffer with a test pattern, one 32-bit pixel per write. It is the source stage upstream of the Wishbone interconnect: its master port is arbitrated with the VGA reader's port onto the SDRAM slave. It writes HDISP×VDISP pixels per frame in raster order. After every BURST accepted writes it releases the bus so the VGA reader can be granted.

---
 rtl/pattern_writer.sv | 128 ++++++++++++
 tb/tb_pattern_writer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_writer.sv
// Wishbone master that paints a test pattern into the SDRAM frame buffer in raster
// order, releasing the bus every BURST acknowledged writes so the display reader can be granted.
module pattern_writer #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          BURST     = 64,
    parameter int          PAUSE_CYC = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        mode,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_ms,
    output logic [3:0]  wb_sel,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_rty,
    output logic        busy,
    output logic        frame_done
);
    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = $clog2(BURST + 1);
    localparam int PW = $clog2(PAUSE_CYC + 1);

    typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;

    state_t          state, state_nxt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [BW-1:0]   bcnt;
    logic [PW-1:0]   pcnt;
    logic            mode_q;
    logic [31:0]     adr_q;
    logic            frame_done_q;
    logic            retry;
    logic            advance;
    logic            last_px;
    logic            burst_end;
    logic            pause_end;

    function automatic logic [31:0] pixel(input logic m, input logic [7:0] px, input logic [7:0] py);
        if (m) return {8'h00, px, py, px ^ py};
        return (px[3:0] == 4'd0 || py[3:0] == 4'd0) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    // ack wins over err/rty; a bare err or rty leaves the same word on the bus
    assign retry     = (wb_err | wb_rty) & ~wb_ack;
    assign advance   = (state == WRITE) & wb_ack & ~retry;
    assign last_px   = (x == XW'(HDISP - 1)) && (y == YW'(VDISP - 1));
    assign burst_end = (bcnt == BW'(BURST - 1));
    assign pause_end = (pcnt == PW'(PAUSE_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable) state_nxt = WRITE;
            WRITE: begin
                if (advance) begin
                    if (last_px)        state_nxt = IDLE;
                    else if (burst_end) state_nxt = PAUSE;
                end
            end
            PAUSE: if (pause_end) state_nxt = enable ? WRITE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x            <= '0;
            y            <= '0;
            bcnt         <= '0;
            pcnt         <= '0;
            mode_q       <= 1'b0;
            adr_q        <= BASE;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= advance && last_px;
            case (state)
                IDLE: begin
                    if (enable) begin
                        x      <= '0;
                        y      <= '0;
                        bcnt   <= '0;
                        mode_q <= mode;
                        adr_q  <= BASE;
                    end
                end
                WRITE: begin
                    pcnt <= '0;
                    if (advance) begin
                        adr_q <= adr_q + 32'd4;
                        if (x == XW'(HDISP - 1)) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                        bcnt <= burst_end ? '0 : bcnt + 1'b1;
                    end
                end
                PAUSE:   pcnt <= pcnt + 1'b1;
                default: pcnt <= '0;
            endcase
        end
    end

    assign wb_cyc     = (state == WRITE);
    assign wb_stb     = (state == WRITE);
    assign wb_we      = (state == WRITE);
    assign wb_sel     = 4'hF;
    assign wb_adr     = adr_q;
    assign wb_dat_ms  = (state == WRITE) ? pixel(mode_q, 8'(x), 8'(y)) : 32'h0000_0000;
    assign busy       = (state != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pattern_writer.sv
// Directed bench for pattern_writer on an 8x4 frame, 4-write tenures, 2-cycle pauses.
module tb_pattern_writer;
    localparam int H = 8;
    localparam int V = 4;
    localparam int B = 4;
    localparam int P = 2;
    localparam int NPIX = H * V;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        enable;
    logic        mode;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_ms;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;
    logic        busy;
    logic        frame_done;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] cap_4c;

    pattern_writer #(
        .HDISP(H), .VDISP(V), .BASE(32'h0000_0000), .BURST(B), .PAUSE_CYC(P)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .mode(mode),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_ms(wb_dat_ms), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
        .wb_rty(wb_rty), .busy(busy), .frame_done(frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pix(input int k, input logic m);
        logic [7:0] px, py;
        px = 8'(k % H);
        py = 8'(k / H);
        if (m) return {8'h00, px, py, px ^ py};
        return (px == 8'd0 || py == 8'd0) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    // Plays a slave for one frame (or the first nk words), checking every bus cycle.
    task automatic run_frame(input int ws, input int rty_at, input int err_at, input logic m,
                             input int flip_at, input int drop_at, input int nk,
                             output int ncyc);
        int k, wcnt, gap, guard;
        bit rdone, edone;
        k = 0; wcnt = 0; gap = 0; guard = 0; rdone = 0; edone = 0; ncyc = 0;
        while (k < nk && guard < 1000) begin
            @(posedge sys_clk); #1;
            guard++;
            ncyc++;
            wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
            check("frame_done_mid", frame_done, 0);
            check("busy_mid", busy, 1);
            if (gap > 0) begin
                check("cyc_pause", wb_cyc, 0);
                gap--;
            end else begin
                check("cyc_tenure", wb_cyc, 1);
                check("stb", wb_stb, 1);
                check("we", wb_we, 1);
                check("sel", wb_sel, 4'hF);
                check("adr", wb_adr, 32'(4 * k));
                check("dat", wb_dat_ms, pix(k, m));
                if (wb_adr == 32'h4C) cap_4c = wb_dat_ms;
                if (k == flip_at) mode = ~m;
                if (k == drop_at) enable = 1'b0;
                if (k == rty_at && !rdone) begin
                    wb_rty = 1'b1;
                    rdone  = 1'b1;
                end else if (k == err_at && !edone) begin
                    wb_err = 1'b1;
                    edone  = 1'b1;
                end else if (wcnt < ws) begin
                    wcnt++;
                end else begin
                    wb_ack = 1'b1;
                    wcnt   = 0;
                    k++;
                    if (k % B == 0 && k < NPIX) gap = P;
                end
            end
        end
        if (k < nk) check("timeout_words", k, nk);
        @(posedge sys_clk); #1;
        ncyc++;
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
        check("cyc_end", wb_cyc, 0);
        check("frame_done_end", frame_done, (nk == NPIX));
        check("busy_end", busy, (nk != NPIX));
    endtask

    initial begin
        int n1, n2, n3, n4, n5, n6, n7, n8, n9;
        sys_rst_n = 1'b0; enable = 1'b0; mode = 1'b0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
        cap_4c = 32'h0;
        #3;
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 0);
        check("rst_adr", wb_adr, 32'h0);
        check("rst_dat", wb_dat_ms, 32'h0);
        check("rst_sel", wb_sel, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check("idle_cyc", wb_cyc, 0);

        // Two back-to-back frames, zero-wait slave, mode 0
        enable = 1'b1;
        run_frame(0, -1, -1, 1'b0, -1, -1, NPIX, n1);
        check("frame1_cycles", n1, 47);
        run_frame(0, -1, -1, 1'b0, -1, -1, NPIX, n2);
        check("frame2_cycles", n2, 47);

        run_frame(3, -1, -1, 1'b0, -1, -1, NPIX, n3);
        check("wait3_cycles", n3, 143);

        run_frame(0, 4, 9, 1'b0, -1, -1, NPIX, n4);
        check("rtyerr_cycles", n4, 49);
        check("rtyerr_shift", n4, n1 + 2);

        // Mode 1 frame with a mid-frame toggle, then the toggled value takes effect
        mode = 1'b1;
        run_frame(0, -1, -1, 1'b1, 10, -1, NPIX, n5);
        check("px_3_2", cap_4c, 32'h0003_0201);
        run_frame(0, -1, -1, 1'b0, -1, -1, NPIX, n6);

        // enable dropped inside the second tenure
        run_frame(0, -1, -1, 1'b0, -1, 5, 8, n7);
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            check("drop_cyc", wb_cyc, 0);
            check("drop_frame_done", frame_done, 0);
            check("drop_busy", busy, (i == 0));
        end
        enable = 1'b1;
        run_frame(0, -1, -1, 1'b0, -1, -1, NPIX, n8);

        // Reset asserted mid-tenure with stb high and no ack
        for (int i = 0; i < 7; i++) begin
            @(posedge sys_clk); #1;
            wb_ack = (i < 4) ? wb_stb : 1'b0;
        end
        check("pre_rst_stb", wb_stb, 1);
        check("pre_rst_adr", wb_adr, 32'h10);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_cyc", wb_cyc, 0);
        check("arst_stb", wb_stb, 0);
        check("arst_adr", wb_adr, 32'h0);
        check("arst_busy", busy, 0);
        check("arst_dat", wb_dat_ms, 32'h0);
        repeat (2) @(posedge sys_clk);
        #1;
        check("arst_hold_cyc", wb_cyc, 0);
        sys_rst_n = 1'b1;
        run_frame(0, -1, -1, 1'b0, -1, -1, NPIX, n9);
        check("post_rst_cycles", n9, 47);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
